// File: rtl/cpu6_mtimer_if.sv
// ---------------------------------------------------------------------------
// cpu6_mtimer_if
// Data-bus port between the cpu6 M-stage load/store path and the machine
// timer window.
//   sel        decoder hit for the timer window
//   re         load strobe
//   memwrite   store strobe
//   addr       byte offset inside the window (low two bits ignored)
//   writedata  store data
//   readdata   load data, returned in the same cycle as the strobe
// ---------------------------------------------------------------------------
interface cpu6_mtimer_if #(
    parameter int XLEN   = 32,
    parameter int OFFS_W = 5
) ();
    logic              sel;
    logic              re;
    logic              memwrite;
    logic [OFFS_W-1:0] addr;
    logic [XLEN-1:0]   writedata;
    logic [XLEN-1:0]   readdata;

    modport master (
        output sel, re, memwrite, addr, writedata,
        input  readdata
    );

    modport slave (
        input  sel, re, memwrite, addr, writedata,
        output readdata
    );
endinterface

// File: rtl/cpu6_mtimer.sv
// ---------------------------------------------------------------------------
// cpu6_mtimer
// RISC-V machine timer (mtime / mtimecmp) with a programmable prescaler,
// mapped as five 32-bit words on the cpu6 data bus.
//   clk        single rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        slave side of cpu6_mtimer_if (decode, strobes, data)
//   tmr_irq_r  registered level interrupt: mtime >= mtimecmp
// Word map: 0 MTIME_LO, 1 MTIME_HI (reads the hi-shadow), 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 CTRL {DIV[15:8], EN[0]}, 5..7 unmapped (read as zero).
// ---------------------------------------------------------------------------
module cpu6_mtimer #(
    parameter int          XLEN      = 32,
    parameter int          OFFS_W    = 5,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    cpu6_mtimer_if.slave    bus,
    output logic            tmr_irq_r
);
    localparam int WIDX_W = OFFS_W - 2;
    localparam logic [WIDX_W-1:0] IDX_MTIME_LO = WIDX_W'(3'd0);
    localparam logic [WIDX_W-1:0] IDX_MTIME_HI = WIDX_W'(3'd1);
    localparam logic [WIDX_W-1:0] IDX_CMP_LO   = WIDX_W'(3'd2);
    localparam logic [WIDX_W-1:0] IDX_CMP_HI   = WIDX_W'(3'd3);
    localparam logic [WIDX_W-1:0] IDX_CTRL     = WIDX_W'(3'd4);

    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              en_q, en_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        pc_q, pc_d;
    logic [XLEN-1:0]   shadow_q, shadow_d;
    logic              irq_q, irq_d;

    logic              wr_s;
    logic              rd_s;
    logic [WIDX_W-1:0] idx_s;
    logic              tick_s;
    logic              ctrl_wr_s;
    logic              unused_addr_s;

    assign wr_s          = bus.sel & bus.memwrite;
    assign rd_s          = bus.sel & bus.re;
    assign idx_s         = bus.addr[OFFS_W-1:2];
    assign ctrl_wr_s     = wr_s & (idx_s == IDX_CTRL);
    assign tick_s        = en_q & (pc_q == div_q);
    // Byte lanes inside a word are not decoded.
    assign unused_addr_s = ^bus.addr[1:0];

    // Prescaler: counts enabled cycles, restarts its phase on any CTRL store.
    always_comb begin
        pc_d = pc_q;
        if (ctrl_wr_s) begin
            pc_d = 8'd0;
        end else if (tick_s) begin
            pc_d = 8'd0;
        end else if (en_q) begin
            pc_d = pc_q + 8'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    // Register file next state: software stores win over the tick increment.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        div_d      = div_q;
        if (wr_s && (idx_s == IDX_MTIME_LO)) begin
            // A store to either half swallows this cycle's tick; no carry.
            mtime_d = {mtime_q[63:32], bus.writedata};
        end else if (wr_s && (idx_s == IDX_MTIME_HI)) begin
            mtime_d = {bus.writedata, mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        if (wr_s && (idx_s == IDX_CMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], bus.writedata};
        end else if (wr_s && (idx_s == IDX_CMP_HI)) begin
            mtimecmp_d = {bus.writedata, mtimecmp_q[31:0]};
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (ctrl_wr_s) begin
            en_d  = bus.writedata[0];
            div_d = bus.writedata[15:8];
        end else begin
            en_d  = en_q;
            div_d = div_q;
        end
    end

    // Hi-shadow: a MTIME_LO load freezes the upper half for a later MTIME_HI load.
    always_comb begin
        shadow_d = shadow_q;
        if (rd_s && (idx_s == IDX_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Interrupt condition from the registered values, one edge of latency.
    always_comb begin
        irq_d = (mtime_q >= mtimecmp_q);
    end

    // Zero-latency load data; idle bus and unmapped words read as zero.
    always_comb begin
        bus.readdata = {XLEN{1'b0}};
        if (rd_s) begin
            case (idx_s)
                IDX_MTIME_LO: bus.readdata = mtime_q[31:0];
                IDX_MTIME_HI: bus.readdata = shadow_q;
                IDX_CMP_LO:   bus.readdata = mtimecmp_q[31:0];
                IDX_CMP_HI:   bus.readdata = mtimecmp_q[63:32];
                IDX_CTRL:     bus.readdata = {16'h0000, div_q, 7'h00, en_q};
                default:      bus.readdata = {XLEN{1'b0}};
            endcase
        end else begin
            bus.readdata = {XLEN{1'b0}};
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= CMP_RESET;
            en_q       <= 1'b0;
            div_q      <= 8'd0;
            pc_q       <= 8'd0;
            shadow_q   <= {XLEN{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            div_q      <= div_d;
            pc_q       <= pc_d;
            shadow_q   <= shadow_d;
            irq_q      <= irq_d;
        end
    end

    assign tmr_irq_r = irq_q;

endmodule

// File: tb/tb_cpu6_mtimer.sv
// ---------------------------------------------------------------------------
// tb_cpu6_mtimer
// Self-checking bench for cpu6_mtimer: a constant vector table for the
// register map, hand-built sequences for the timing corners, then random
// bus traffic checked against a behavioural model of the timer.
// ---------------------------------------------------------------------------
module tb_cpu6_mtimer;

    logic clk;
    logic reset;
    logic tmr_irq;

    cpu6_mtimer_if #(.XLEN(32), .OFFS_W(5)) bus_if ();

    cpu6_mtimer #(
        .XLEN      (32),
        .OFFS_W    (5),
        .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .tmr_irq_r (tmr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_div;
    int          m_phase;   // enabled cycles since the last CTRL store
    logic [31:0] m_shadow;
    logic        m_irq;

    typedef struct {
        logic        s;
        logic        r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_time   = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en     = 1'b0;
        m_div    = 8'd0;
        m_phase  = 0;
        m_shadow = 32'd0;
        m_irq    = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic s, input logic r, input logic [4:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (s && r) begin
            case (a[4:2])
                3'd0:    v = m_time[31:0];
                3'd1:    v = m_shadow;
                3'd2:    v = m_cmp[31:0];
                3'd3:    v = m_cmp[63:32];
                3'd4:    v = {16'd0, m_div, 7'd0, m_en};
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    task automatic model_step(input logic s, input logic r, input logic w,
                              input logic [4:0] a, input logic [31:0] d);
        logic       wr;
        logic       rd;
        logic       tick;
        logic [2:0] ix;
        wr   = s && w;
        rd   = s && r;
        ix   = a[4:2];
        tick = m_en && ((m_phase % (int'(m_div) + 1)) == int'(m_div));
        m_irq = (m_time >= m_cmp);
        if (rd && ix == 3'd0) m_shadow = m_time[63:32];
        if (wr && ix == 3'd0)      m_time[31:0]  = d;
        else if (wr && ix == 3'd1) m_time[63:32] = d;
        else if (tick)             m_time = m_time + 64'd1;
        if (wr && ix == 3'd2) m_cmp[31:0]  = d;
        if (wr && ix == 3'd3) m_cmp[63:32] = d;
        if (wr && ix == 3'd4) begin
            m_en    = d[0];
            m_div   = d[15:8];
            m_phase = 0;
        end else if (m_en) begin
            m_phase++;
        end
    endtask

    // One bus cycle: drive at the falling edge, check load data before the
    // rising edge, check the interrupt after it. Ends on the next falling edge.
    task automatic bus_cycle(input logic s, input logic r, input logic w,
                             input logic [4:0] a, input logic [31:0] d,
                             input bit hand, input logic [31:0] h_rd, input string nm);
        logic [31:0] e;
        bus_if.sel       = s;
        bus_if.re        = r;
        bus_if.memwrite  = w;
        bus_if.addr      = a;
        bus_if.writedata = d;
        #1;
        e = hand ? h_rd : model_rd(s, r, a);
        chk({nm, "_rd"}, bus_if.readdata, e);
        model_step(s, r, w, a, d);
        @(posedge clk);
        #1;
        chk({nm, "_irq"}, {31'd0, tmr_irq}, {31'd0, m_irq});
        @(negedge clk);
    endtask

    task automatic rd_word(input logic [4:0] a, input logic [31:0] exp, input string nm);
        bus_cycle(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, exp, nm);
    endtask

    task automatic wr_word(input logic [4:0] a, input logic [31:0] d, input string nm);
        bus_cycle(1'b1, 1'b0, 1'b1, a, d, 1'b1, 32'd0, nm);
    endtask

    task automatic idle(input string nm);
        bus_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ra;
        logic [31:0] rdat;
        logic        rs, rr, rw;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'h08, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'h0C, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'h0,         32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 5'h10, 32'h0,         32'h0,         1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 5'h08, 32'h3,         32'h0,         1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'h0C, 32'h0,         32'h0,         1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'h08, 32'h0,         32'h0,         1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 5'h0B, 32'h0,         32'h3,         1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 5'h14, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'h18, 32'h0,         32'h0,         1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'h0,         32'h0,         1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 5'h10, 32'h0000_AB00, 32'h0,         1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 5'h10, 32'h0,         32'h0000_AB00, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 5'h10, 32'hFFFF_00FE, 32'h0,         1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 5'h10, 32'h0,         32'h0,         1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 5'h08, 32'h0,         32'h0,         1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 5'h0C, 32'h0,         32'h0,         1'b0};

        reset            = 1'b0;
        bus_if.sel       = 1'b0;
        bus_if.re        = 1'b0;
        bus_if.memwrite  = 1'b0;
        bus_if.addr      = 5'd0;
        bus_if.writedata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_irq", {31'd0, tmr_irq}, 32'd0);
        reset = 1'b1;

        // Idle after reset: timer disabled, no interrupt
        for (int i = 0; i < 100; i++) idle("t1_idle");
        rd_word(5'h00, 32'h0, "t1_mtime_lo");

        // Register map and unmapped window
        for (int i = 0; i < 17; i++) begin
            bus_cycle(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                      1'b1, tbl[i].exp_rd, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_hirq", i), {31'd0, tmr_irq}, {31'd0, tbl[i].exp_irq});
        end

        // DIV 0 counting and compare latency; cmp = 3
        wr_word(5'h10, 32'h1, "t2_en");
        for (int i = 0; i < 3; i++) begin
            idle("t2_cnt");
            chk("t2_irq_low", {31'd0, tmr_irq}, 32'd0);
        end
        rd_word(5'h00, 32'h3, "t2_at3");
        chk("t2_irq_high", {31'd0, tmr_irq}, 32'd1);
        wr_word(5'h08, 32'd100, "t2_cmp100");
        chk("t2_irq_hold", {31'd0, tmr_irq}, 32'd1);
        idle("t2_clear");
        chk("t2_irq_clear", {31'd0, tmr_irq}, 32'd0);

        // DIV 4: one tick per 5 cycles, phase restarted by a CTRL store
        wr_word(5'h10, 32'h0000_0400, "t3_dis");
        wr_word(5'h00, 32'h10, "t3_lo");
        wr_word(5'h04, 32'h0, "t3_hi");
        wr_word(5'h10, 32'h0000_0401, "t3_en");
        for (int i = 0; i < 5; i++) rd_word(5'h00, 32'h10, "t3_ph1");
        for (int i = 0; i < 3; i++) rd_word(5'h00, 32'h11, "t3_tick1");
        wr_word(5'h10, 32'h0000_0401, "t3_rewr");
        for (int i = 0; i < 5; i++) rd_word(5'h00, 32'h11, "t3_ph2");
        rd_word(5'h00, 32'h12, "t3_tick2");

        // Atomic 64-bit read across the low-word carry
        wr_word(5'h10, 32'h0, "t4_dis");
        wr_word(5'h00, 32'hFFFF_FFFF, "t4_lo");
        wr_word(5'h04, 32'h0, "t4_hi");
        wr_word(5'h10, 32'h1, "t4_en");
        rd_word(5'h00, 32'hFFFF_FFFF, "t4_rd_lo");
        idle("t4_gap");
        rd_word(5'h04, 32'h0, "t4_rd_shadow");
        rd_word(5'h00, 32'h2, "t4_rd_lo2");
        rd_word(5'h04, 32'h1, "t4_rd_shadow2");

        // Store to MTIME_LO swallows the simultaneous tick
        wr_word(5'h00, 32'h50, "t5_wr");
        rd_word(5'h00, 32'h50, "t5_lo");
        rd_word(5'h04, 32'h1, "t5_hi");

        // Asynchronous reset with interrupt asserted
        chk("t6_irq_pre", {31'd0, tmr_irq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_irq_async", {31'd0, tmr_irq}, 32'd0);
        bus_if.sel      = 1'b1;
        bus_if.re       = 1'b1;
        bus_if.memwrite = 1'b0;
        bus_if.addr     = 5'h00;
        #1;
        chk("t6_mtime_lo", bus_if.readdata, 32'h0);
        bus_if.addr = 5'h08;
        #1;
        chk("t6_cmp_lo", bus_if.readdata, 32'hFFFF_FFFF);
        bus_if.addr = 5'h10;
        #1;
        chk("t6_ctrl", bus_if.readdata, 32'h0);
        bus_if.sel = 1'b0;
        bus_if.re  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle("t6_after");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom_range(0, 7) != 0);
            rr = $urandom_range(0, 1) == 1;
            rw = $urandom_range(0, 2) == 0;
            ra = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            case (ra[4:2])
                3'd1, 3'd3: rdat = 32'($urandom_range(0, 1));
                3'd0, 3'd2: rdat = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                               : 32'($urandom_range(0, 400));
                3'd4:       rdat = {16'($urandom), 8'($urandom_range(0, 3)), 7'($urandom),
                                    1'($urandom_range(0, 4) != 0)};
                default:    rdat = $urandom;
            endcase
            bus_cycle(rs, rr, rw, ra, rdat, 1'b0, 32'd0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
